uart_rx_cmd_ctrl: RTL and testbench
===================================

// Module: uart_rx_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver. Consumes received bytes (PDATA + Data_Valid pulse),
//  decodes framed commands, and issues register-file writes and reads. Forwards read data to the
//  UART transmitter over a valid/ready handshake. Owns the receiver config (prescale, parity enable/type).
// PARAMETERS
//  ADDR_W     4      register-file address width; low ADDR_W bits of the address byte are used
//  TO_CYCLES  50000  inter-byte / read-response timeout in clock cycles (>=2)
//  TO_W       16     timeout counter width; must hold TO_CYCLES-1
// PORTS
//  RxCmd_CLK           in   1       single clock
//  RxCmd_RST           in   1       synchronous, active-high reset
//  RxCmd_RX_PDATA      in   8       byte from UART receiver
//  RxCmd_RX_Valid      in   1       1-cycle pulse: RX_PDATA holds a good byte
//  RxCmd_RF_WrEn       out  1       1-cycle register-file write strobe
//  RxCmd_RF_RdEn       out  1       1-cycle register-file read strobe
//  RxCmd_RF_Addr       out  ADDR_W  register-file address (held from address byte)
//  RxCmd_RF_WrData     out  8       register-file write data
//  RxCmd_RF_RdData     in   8       register-file read data
//  RxCmd_RF_RdValid    in   1       RF_RdData valid this cycle
//  RxCmd_TX_Data       out  8       byte to UART transmitter
//  RxCmd_TX_Valid      out  1       TX_Data valid; held until accepted
//  RxCmd_TX_Ready      in   1       transmitter accepts when TX_Valid & TX_Ready at clock edge
//  RxCmd_Prescale      out  5       receiver oversampling prescale
//  RxCmd_PAR_EN        out  1       receiver parity enable
//  RxCmd_PAR_TYP       out  1       receiver parity type (0 even, 1 odd)
//  RxCmd_Busy          out  1       1 whenever state != IDLE
//  RxCmd_Cmd_Err       out  1       1-cycle pulse: unknown opcode, dropped byte, or bad config
//  RxCmd_Frame_Err     out  1       1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (clock edge with RST=1): state IDLE; RF_WrEn, RF_RdEn, TX_Valid, Cmd_Err, Frame_Err = 0.
//   RF_Addr, RF_WrData, TX_Data = 0. Prescale = 8, PAR_EN = 1, PAR_TYP = 0. Timeout counter = 0.
//   Reset mid-command discards the command and emits no strobe.
//  Frames: 0xAA,addr,data = write; 0xBB,addr = read; 0xCC,cfg = config.
//  FSM:
//   IDLE:     on RX_Valid, 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->CFG_DATA; any other byte -> Cmd_Err pulse, stay.
//   WR_ADDR:  on byte, latch RF_Addr -> WR_DATA.
//   WR_DATA:  on byte, latch RF_WrData. Pulse RF_WrEn in the next cycle (1-cycle latency) -> IDLE.
//   RD_ADDR:  on byte, latch RF_Addr. Pulse RF_RdEn in the next cycle -> RD_WAIT.
//   RD_WAIT:  on RF_RdValid, latch TX_Data -> TX_SEND.
//   TX_SEND:  TX_Valid=1, TX_Data stable. When TX_Ready=1 at an edge -> IDLE (TX_Valid low next cycle).
//   CFG_DATA: byte cfg = {rsv, PAR_TYP, PAR_EN, PRESCALE[4:0]}.
//    If PRESCALE is 8 or 16: update all three outputs in the next cycle.
//    Otherwise: leave config unchanged and pulse Cmd_Err. Both cases -> IDLE.
//  RX_Valid in RD_WAIT or TX_SEND: byte dropped, Cmd_Err pulse, state unchanged.
//  RF_RdValid outside RD_WAIT: ignored.
//  Timeout: counter runs in WR_ADDR/WR_DATA/RD_ADDR/CFG_DATA/RD_WAIT. It clears on state entry and on each accepted byte.
//   When it reaches TO_CYCLES-1 with no byte/RdValid that cycle: -> IDLE, Frame_Err pulse, no strobe.
//   A byte (or RdValid) in the expiry cycle wins: the event is accepted and no Frame_Err is raised.
//   No timeout in TX_SEND or IDLE.
//  Strobes and error pulses are registered, never overlap one another, and each is exactly 1 cycle.
// TESTING
//  Write: RX 0xAA,0x05,0x3C -> one RF_WrEn cycle with Addr=5, WrData=0x3C, 1 cycle after 3rd Valid; Busy low after.
//  Read + backpressure: RX 0xBB,0x02; RF returns 0x7E after 3 cycles; TX_Ready low for 10 cycles ->
//   TX_Valid held with TX_Data=0x7E for 10 cycles, drops 1 cycle after Ready.
//  Config: RX 0xCC,0x70 -> Prescale=16, PAR_EN=1, PAR_TYP=1.
//   Then RX 0xCC,0x0C -> Cmd_Err pulse, config unchanged.
//  Errors: RX 0x55 in IDLE -> Cmd_Err, stay IDLE. RX byte during RD_WAIT -> Cmd_Err, still waiting.
//  Timeout (TO_CYCLES=20): RX 0xAA then silence -> Frame_Err at cycle 20, IDLE, no WrEn.
//   Byte landing exactly at expiry cycle -> accepted, no Frame_Err.
//  Reset mid-frame: RX 0xAA,0x01, assert RST 1 cycle -> IDLE, config defaults.
//   Next 0xAA,0x03,0x11 writes Addr=3 normally.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes write/read/config frames into register-file strobes.
// Latency: RF strobes and config updates appear 1 cycle after the final frame byte; read data is forwarded 1 cycle after RdValid.
// Backpressure: TX_Valid/TX_Data are held until TX_Ready; bytes arriving while a read is in flight are dropped with Cmd_Err.
module uart_rx_cmd_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int TO_CYCLES = 50000,
  parameter int TO_W      = 16
) (
  input  logic              RxCmd_CLK,
  input  logic              RxCmd_RST,
  input  logic [7:0]        RxCmd_RX_PDATA,
  input  logic              RxCmd_RX_Valid,
  output logic              RxCmd_RF_WrEn,
  output logic              RxCmd_RF_RdEn,
  output logic [ADDR_W-1:0] RxCmd_RF_Addr,
  output logic [7:0]        RxCmd_RF_WrData,
  input  logic [7:0]        RxCmd_RF_RdData,
  input  logic              RxCmd_RF_RdValid,
  output logic [7:0]        RxCmd_TX_Data,
  output logic              RxCmd_TX_Valid,
  input  logic              RxCmd_TX_Ready,
  output logic [4:0]        RxCmd_Prescale,
  output logic              RxCmd_PAR_EN,
  output logic              RxCmd_PAR_TYP,
  output logic              RxCmd_Busy,
  output logic              RxCmd_Cmd_Err,
  output logic              RxCmd_Frame_Err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    RD_ADDR  = 3'd3,
    RD_WAIT  = 3'd4,
    TX_SEND  = 3'd5,
    CFG_DATA = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t            state_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        tx_data_q;
  logic              tx_vld_q;
  logic [4:0]        prescale_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              cmd_err_q;
  logic              frame_err_q;

  logic to_expired;
  logic cfg_ok;

  assign to_expired = (to_cnt_q == TO_LAST);
  // Only the two oversampling ratios the receiver supports are accepted.
  assign cfg_ok     = (RxCmd_RX_PDATA[4:0] == 5'd8) || (RxCmd_RX_PDATA[4:0] == 5'd16);

  // Frame decoder, timeout counter and all registered outputs.
  always_ff @(posedge RxCmd_CLK) begin
    if (RxCmd_RST) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      prescale_q  <= 5'd8;
      par_en_q    <= 1'b1;
      par_typ_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (RxCmd_RX_Valid) begin
            case (RxCmd_RX_PDATA)
              8'hAA:   state_q   <= WR_ADDR;
              8'hBB:   state_q   <= RD_ADDR;
              8'hCC:   state_q   <= CFG_DATA;
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        WR_ADDR, WR_DATA, RD_ADDR, CFG_DATA: begin
          // A byte in the expiry cycle takes priority over the abort.
          if (RxCmd_RX_Valid) begin
            to_cnt_q <= '0;
            case (state_q)
              WR_ADDR: begin
                addr_q  <= RxCmd_RX_PDATA[ADDR_W-1:0];
                state_q <= WR_DATA;
              end
              WR_DATA: begin
                wr_data_q <= RxCmd_RX_PDATA;
                wr_en_q   <= 1'b1;
                state_q   <= IDLE;
              end
              RD_ADDR: begin
                addr_q  <= RxCmd_RX_PDATA[ADDR_W-1:0];
                rd_en_q <= 1'b1;
                state_q <= RD_WAIT;
              end
              default: begin
                if (cfg_ok) begin
                  prescale_q <= RxCmd_RX_PDATA[4:0];
                  par_en_q   <= RxCmd_RX_PDATA[5];
                  par_typ_q  <= RxCmd_RX_PDATA[6];
                end else begin
                  cmd_err_q <= 1'b1;
                end
                state_q <= IDLE;
              end
            endcase
          end else if (to_expired) begin
            frame_err_q <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        RD_WAIT: begin
          if (RxCmd_RX_Valid) cmd_err_q <= 1'b1;
          if (RxCmd_RF_RdValid) begin
            tx_data_q <= RxCmd_RF_RdData;
            tx_vld_q  <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= TX_SEND;
          end else if (to_expired) begin
            // A dropped byte at expiry already pulses Cmd_Err; hold the count
            // so the abort follows one cycle later instead of overlapping it.
            if (!RxCmd_RX_Valid) begin
              frame_err_q <= 1'b1;
              to_cnt_q    <= '0;
              state_q     <= IDLE;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        TX_SEND: begin
          if (RxCmd_RX_Valid) cmd_err_q <= 1'b1;
          if (RxCmd_TX_Ready) begin
            tx_vld_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RxCmd_RF_WrEn    = wr_en_q;
  assign RxCmd_RF_RdEn    = rd_en_q;
  assign RxCmd_RF_Addr    = addr_q;
  assign RxCmd_RF_WrData  = wr_data_q;
  assign RxCmd_TX_Data    = tx_data_q;
  assign RxCmd_TX_Valid   = tx_vld_q;
  assign RxCmd_Prescale   = prescale_q;
  assign RxCmd_PAR_EN     = par_en_q;
  assign RxCmd_PAR_TYP    = par_typ_q;
  assign RxCmd_Busy       = (state_q != IDLE);
  assign RxCmd_Cmd_Err    = cmd_err_q;
  assign RxCmd_Frame_Err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Testbench for uart_rx_cmd_ctrl: scoreboarded writes and read responses plus cycle-exact checks.
// Timing: inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// Backpressure: TX_Ready is held low for a stretch to confirm TX_Valid/TX_Data hold.
module tb_uart_rx_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_pdata;
  logic       rx_valid;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       busy;
  logic       cmd_err;
  logic       frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int cmd_cnt = 0;
  int fe_cnt = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0, prev_cmd = 1'b0, prev_fe = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl #(.ADDR_W(4), .TO_CYCLES(20), .TO_W(5)) dut (
    .RxCmd_CLK        (clk),
    .RxCmd_RST        (rst),
    .RxCmd_RX_PDATA   (rx_pdata),
    .RxCmd_RX_Valid   (rx_valid),
    .RxCmd_RF_WrEn    (rf_wr_en),
    .RxCmd_RF_RdEn    (rf_rd_en),
    .RxCmd_RF_Addr    (rf_addr),
    .RxCmd_RF_WrData  (rf_wr_data),
    .RxCmd_RF_RdData  (rf_rd_data),
    .RxCmd_RF_RdValid (rf_rd_valid),
    .RxCmd_TX_Data    (tx_data),
    .RxCmd_TX_Valid   (tx_valid),
    .RxCmd_TX_Ready   (tx_ready),
    .RxCmd_Prescale   (prescale),
    .RxCmd_PAR_EN     (par_en),
    .RxCmd_PAR_TYP    (par_typ),
    .RxCmd_Busy       (busy),
    .RxCmd_Cmd_Err    (cmd_err),
    .RxCmd_Frame_Err  (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte so it is sampled at the next rising edge; returns just after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx_pdata = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Scoreboard pops, pulse counting, pulse width and non-overlap checks.
  always @(negedge clk) begin
    if (!rst) begin
      logic [11:0] we;
      logic [7:0]  te;
      if (rf_wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          we = wr_q.pop_front();
          chk("wr_addr", 32'(rf_addr), 32'(we[11:8]));
          chk("wr_data", 32'(rf_wr_data), 32'(we[7:0]));
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          te = tx_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(te));
        end
      end
      if (rf_rd_en) rd_cnt++;
      if (cmd_err) cmd_cnt++;
      if (frame_err) fe_cnt++;
      if (rf_wr_en | rf_rd_en | cmd_err | frame_err)
        chk("pulse_overlap", 32'($countones({rf_wr_en, rf_rd_en, cmd_err, frame_err})), 1);
      if (rf_wr_en)  chk("wr_en_width", 32'(prev_wr), 0);
      if (rf_rd_en)  chk("rd_en_width", 32'(prev_rd), 0);
      if (cmd_err)   chk("cmd_err_width", 32'(prev_cmd), 0);
      if (frame_err) chk("frame_err_width", 32'(prev_fe), 0);
    end
    prev_wr  = rf_wr_en;
    prev_rd  = rf_rd_en;
    prev_cmd = cmd_err;
    prev_fe  = frame_err;
  end

  initial begin
    rst = 1'b1;
    rx_pdata = 8'h00;
    rx_valid = 1'b0;
    rf_rd_data = 8'h00;
    rf_rd_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_wr_en", 32'(rf_wr_en), 0);
    chk("rst_rd_en", 32'(rf_rd_en), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_addr", 32'(rf_addr), 0);
    chk("rst_wr_data", 32'(rf_wr_data), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_prescale", 32'(prescale), 8);
    chk("rst_par_en", 32'(par_en), 1);
    chk("rst_par_typ", 32'(par_typ), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Write frame
    wr_q.push_back({4'h5, 8'h3C});
    send_byte(8'hAA);
    send_byte(8'h05);
    chk("wr_busy_mid", 32'(busy), 1);
    send_byte(8'h3C);
    chk("wr_strobe", 32'(rf_wr_en), 1);
    chk("wr_busy_after", 32'(busy), 0);
    tick();
    chk("wr_strobe_end", 32'(rf_wr_en), 0);

    // Read with 10 cycles of TX backpressure
    tx_q.push_back(8'h7E);
    send_byte(8'hBB);
    send_byte(8'h02);
    chk("rd_strobe", 32'(rf_rd_en), 1);
    chk("rd_addr", 32'(rf_addr), 2);
    tick();
    tick();
    rf_rd_data = 8'h7E;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", 32'(tx_valid), 1);
      chk("bp_tx_data", 32'(tx_data), 32'h7E);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_drop", 32'(tx_valid), 0);
    chk("tx_busy_after", 32'(busy), 0);

    // RdValid while idle is ignored
    rf_rd_data = 8'hEE;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    chk("stray_rdvalid_busy", 32'(busy), 0);
    chk("stray_rdvalid_tx", 32'(tx_valid), 0);

    // Config: accepted, then rejected
    send_byte(8'hCC);
    send_byte(8'h70);
    chk("cfg_prescale", 32'(prescale), 16);
    chk("cfg_par_en", 32'(par_en), 1);
    chk("cfg_par_typ", 32'(par_typ), 1);
    send_byte(8'hCC);
    send_byte(8'h0C);
    chk("badcfg_cmd_err", 32'(cmd_err), 1);
    chk("badcfg_prescale", 32'(prescale), 16);
    chk("badcfg_par_typ", 32'(par_typ), 1);
    tick();

    // Unknown opcode in IDLE
    send_byte(8'h55);
    chk("badop_cmd_err", 32'(cmd_err), 1);
    chk("badop_busy", 32'(busy), 0);
    tick();

    // Byte dropped while waiting for read data
    tx_q.push_back(8'hA5);
    send_byte(8'hBB);
    send_byte(8'h09);
    tick();
    send_byte(8'h77);
    chk("rdwait_cmd_err", 32'(cmd_err), 1);
    chk("rdwait_busy", 32'(busy), 1);
    chk("rdwait_tx_valid", 32'(tx_valid), 0);
    rf_rd_data = 8'hA5;
    rf_rd_valid = 1'b1;
    tx_ready = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    chk("rd2_tx_valid", 32'(tx_valid), 1);
    chk("rd2_tx_data", 32'(tx_data), 32'hA5);
    tick();
    tx_ready = 1'b0;
    chk("rd2_tx_drop", 32'(tx_valid), 0);

    // Timeout: opcode then silence
    send_byte(8'hAA);
    repeat (19) tick();
    chk("to_not_yet", 32'(frame_err), 0);
    chk("to_busy_before", 32'(busy), 1);
    tick();
    chk("to_frame_err", 32'(frame_err), 1);
    chk("to_busy_after", 32'(busy), 0);
    chk("to_no_wr", 32'(rf_wr_en), 0);
    tick();

    // Byte exactly at the expiry cycle is accepted
    wr_q.push_back({4'h4, 8'h99});
    send_byte(8'hAA);
    repeat (19) tick();
    send_byte(8'h04);
    chk("expiry_byte_no_fe", 32'(frame_err), 0);
    chk("expiry_byte_busy", 32'(busy), 1);
    send_byte(8'h99);
    chk("expiry_wr_strobe", 32'(rf_wr_en), 1);
    tick();

    // Reset in the middle of a frame
    send_byte(8'hAA);
    send_byte(8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_prescale", 32'(prescale), 8);
    chk("midrst_par_en", 32'(par_en), 1);
    chk("midrst_par_typ", 32'(par_typ), 0);
    chk("midrst_wr_en", 32'(rf_wr_en), 0);
    wr_q.push_back({4'h3, 8'h11});
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    chk("postrst_wr_strobe", 32'(rf_wr_en), 1);
    chk("postrst_addr", 32'(rf_addr), 3);
    repeat (3) tick();

    // Totals
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("tx_q_empty", 32'(tx_q.size()), 0);
    chk("wr_count", wr_cnt, 3);
    chk("rd_count", rd_cnt, 2);
    chk("cmd_err_count", cmd_cnt, 3);
    chk("frame_err_count", fe_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
